uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- Asynchronous serial (8N1) receiver that feeds the memory-controller path.
- Drives rx_data/rx_done, which the controller consumes as write data plus write strobe.
- Single clock domain: oversamples the raw serial pin with a bit-period counter and resolves each frame at mid-bit.
- Produces a one-cycle completion pulse per valid byte and a one-cycle framing-error pulse per bad stop bit.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (434 at defaults), derived localparam; integer division, truncated.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- rx  input  1  raw serial line; idle high; asynchronous to clk.
- rx_data  output  8  last correctly received byte, LSB-first reassembled; holds between frames.
- rx_done  output  1  one-cycle pulse; rx_data is valid in the same cycle and stays valid afterwards.
- rx_busy  output  1  high while a frame is being received (any state except IDLE).
- frame_err  output  1  one-cycle pulse when the stop bit samples low.

Behaviour:
- Clock and reset: one clock (clk); reset n_rst is asynchronous, active-low.
- Reset values: rx_data=8'h00, rx_done=0, rx_busy=0, frame_err=0, state=IDLE, synchronizer flops=1, counters=0.
- Input path: 2-flop synchronizer on rx, producing rx_s; all decisions use rx_s only.
- Bit counter: cnt counts 0..CLKS_PER_BIT-1. bit_idx is 3 bits.
- IDLE:
  - On rx_s==0, clear cnt and go to START.
- START:
  - When cnt==CLKS_PER_BIT/2-1, resample.
  - rx_s==1: false start; return to IDLE with no pulses.
  - Otherwise clear cnt, set bit_idx=0, go to DATA.
- DATA:
  - When cnt==CLKS_PER_BIT-1, shift rx_s into shift register bit[bit_idx] (LSB first).
  - bit_idx==7 goes to STOP (or PARITY); otherwise bit_idx++.
- STOP:
  - When cnt==CLKS_PER_BIT-1, sample.
  - 1: rx_data<=shift register and rx_done=1 for exactly one cycle; go to IDLE.
  - 0: frame_err=1 for one cycle; rx_data unchanged; no rx_done; go to BREAK.
- BREAK:
  - Wait for rx_s==1, then go to IDLE. This prevents a held-low line (break) from retriggering frames.
- Latency: rx_done rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks (±1) after the start-bit falling edge at the rx pin.
- Back-to-back frames: IDLE is re-entered at mid-stop bit, so a start bit immediately following the stop bit is caught. No inter-frame gap is required.
- rx_done and frame_err are never high in the same cycle, and neither is ever high for more than one cycle.
- Reset mid-frame: the partial frame is discarded and no pulse is generated. After release, the block waits in IDLE for a fresh falling edge; a line still low mid-frame at release is treated as a start.
- rx_busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It samples at full-period end and checks even parity over the 8 data bits plus the parity bit.
  - On mismatch, the frame completes normally through STOP, but rx_done is suppressed, rx_data is not updated, and an extra output parity_err pulses for one cycle at stop-sample time.
  - A frame can raise parity_err and frame_err together in the same cycle.
- Not defined: no PARITY state, no parity_err port, 8N1 only.

Decomposition:
- Shared package uart_pkg:
  - state enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - function computing CLKS_PER_BIT from CLK_FREQ and BAUD.
  - constants DATA_BITS=8 and STOP_SAMPLE=1'b1.
- One natural sub-module: sync_2ff (generic 2-flop synchronizer, reset value parameterized to 1). Everything else stays in the top FSM.

Test Plan (bench uses CLK_FREQ=1000000, BAUD=100000, so CLKS_PER_BIT=10):
- Send 8'hA5 8N1 -> one rx_done pulse ~97 clocks after the start edge, rx_data=8'hA5, frame_err stays 0, rx_busy low afterwards.
- Send 8'h3C then 8'hC3 back-to-back with no idle gap -> two rx_done pulses; rx_data=8'h3C after the first, then 8'hC3.
- 3-clock low glitch on idle rx -> false start; no rx_done, no frame_err; rx_busy high briefly, then 0.
- Send 8'h55 with stop bit forced 0 and line held low 50 clocks -> one frame_err pulse; rx_data keeps its prior value; no retrigger until the line goes high; next frame 8'h12 received correctly.
- Assert n_rst at bit 4 of a frame for 2 clocks, then idle the line -> no pulses, all outputs at reset values; next frame 8'hFF received.
- With UART_RX_PARITY_EN: send 8'h07 with even-parity bit 1 -> rx_done, rx_data=8'h07; same byte with parity bit 0 -> parity_err pulse, no rx_done.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receive path:
//               receiver state encoding, data/stop framing constants and
//               the bit-period helper function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Explicit 3-bit encoding; PARITY is only visited when the parity option
  // is compiled in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic STOP_SAMPLE = 1'b1;

  // Clocks per serial bit, truncated integer division.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Generic two-flop synchronizer for a single asynchronous bit.
//               Both flops reset to RESET_VAL so an idle-high line does not
//               produce a spurious edge out of reset.
// Ports       : clk   - destination clock
//               n_rst - asynchronous active-low reset
//               i_d   - asynchronous input
//               o_q   - synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx_frame.sv
// ============================================================================
// Module      : uart_rx_frame
// Description : 8N1 asynchronous serial receiver. The raw line is
//               synchronized, the start bit is verified at mid-bit and every
//               following bit is sampled one full bit period later, i.e. at
//               the centre of each bit cell.
//               Optional macro UART_RX_PARITY_EN adds an even-parity bit
//               between data and stop, plus a parity_err output.
// Ports       : clk        - system clock, rising edge
//               n_rst      - asynchronous active-low reset
//               rx         - raw serial line, idle high
//               rx_data    - last correctly received byte (holds)
//               rx_done    - one-cycle pulse, rx_data valid in same cycle
//               rx_busy    - high whenever the receiver is not IDLE
//               frame_err  - one-cycle pulse when the stop bit samples low
//               parity_err - (UART_RX_PARITY_EN only) one-cycle pulse on
//                            parity mismatch, at stop-sample time
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int c_CNT_W      = $clog2(CLKS_PER_BIT);

  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [2:0]         c_LAST_BIT = 3'(DATA_BITS - 1);

  state_t               r_state,     w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt,       w_cnt_nxt;
  logic [2:0]           r_bit_idx,   w_bit_idx_nxt;
  logic [7:0]           r_shift,     w_shift_nxt;
  logic [7:0]           r_data,      w_data_nxt;
  logic                 r_done,      w_done_nxt;
  logic                 r_frame_err, w_frame_err_nxt;
  logic                 r_busy,      w_busy_nxt;
  logic                 w_rx_s;
  logic                 w_par_ok;

`ifdef UART_RX_PARITY_EN
  logic                 r_par_bit,   w_par_bit_nxt;
  logic                 r_par_err,   w_par_err_nxt;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign w_par_ok = ~(^{r_shift, r_par_bit});
`else
  assign w_par_ok = 1'b1;
`endif

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= 8'h00;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit   <= 1'b0;
      r_par_err   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_data      <= w_data_nxt;
      r_done      <= w_done_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_busy      <= w_busy_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_bit   <= w_par_bit_nxt;
      r_par_err   <= w_par_err_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_data_nxt      = r_data;
    w_done_nxt      = 1'b0;
    w_frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bit_nxt   = r_par_bit;
    w_par_err_nxt   = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_cnt_nxt   = '0;
          w_state_nxt = START;
        end
      end

      // Re-check the line at mid start bit; a high level means a glitch.
      START: begin
        if (r_cnt == c_CNT_HALF) begin
          if (w_rx_s) begin
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt     = '0;
            w_bit_idx_nxt = '0;
            w_state_nxt   = DATA;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end

      // Counting a full period from mid start bit lands on mid data bit.
      DATA: begin
        if (r_cnt == c_CNT_FULL) begin
          w_shift_nxt[r_bit_idx] = w_rx_s;
          w_cnt_nxt              = '0;
          if (r_bit_idx == c_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (r_cnt == c_CNT_FULL) begin
          w_par_bit_nxt = w_rx_s;
          w_cnt_nxt     = '0;
          w_state_nxt   = STOP;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
`endif

      // Leaving at mid stop bit lets a start bit that directly follows the
      // stop bit be caught without any inter-frame gap.
      STOP: begin
        if (r_cnt == c_CNT_FULL) begin
          w_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
          w_par_err_nxt = ~w_par_ok;
`endif
          if (w_rx_s == STOP_SAMPLE) begin
            if (w_par_ok) begin
              w_data_nxt = r_shift;
              w_done_nxt = 1'b1;
            end
            w_state_nxt = IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end

      // Hold off until the line returns high so a break cannot retrigger.
      BREAK: begin
        if (w_rx_s) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign rx_data   = r_data;
  assign rx_done   = r_done;
  assign rx_busy   = r_busy;
  assign frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_par_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
// ============================================================================
// Module      : tb_uart_rx_frame
// Description : Self-checking bench for uart_rx_frame. A frame-level model
//               records, for every frame sent, the cycle and kind of pulse
//               the receiver must produce; a per-cycle comparator checks
//               rx_done, frame_err, rx_data (and parity_err when
//               UART_RX_PARITY_EN is defined) against it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_frame;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int CPB      = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam int LAT_LIT    = 108;
`else
  localparam int FRAME_BITS = 10;
  localparam int LAT_LIT    = 98;
`endif
  // Start edge to rx_done: two sync flops, half a bit to the centre of the
  // start bit, the remaining bits to mid stop bit, one output register.
  localparam int LAT = 2 + CPB / 2 + (FRAME_BITS - 1) * CPB + 1;

  logic       clk   = 1'b0;
  logic       n_rst = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_frame #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  // Model state: expected pulses keyed by cycle, plus the last good byte.
  bit         exp_done [int];
  logic [7:0] exp_byte [int];
  bit         exp_ferr [int];
  bit         exp_perr [int];
  logic [7:0] model_data    = 8'h00;
  int         last_done_cyc = -1;
  int         done_count    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  always @(negedge clk) begin : cmp
    bit ed;
    bit ef;
    bit ep;
    if (!n_rst) model_data = 8'h00;
    ed = exp_done.exists(cyc);
    ef = exp_ferr.exists(cyc);
    ep = exp_perr.exists(cyc);
    if (ed) model_data = exp_byte[cyc];
    check("rx_done",   {31'b0, rx_done},   {31'b0, ed});
    check("frame_err", {31'b0, frame_err}, {31'b0, ef});
    check("rx_data",   {24'b0, rx_data},   {24'b0, model_data});
`ifdef UART_RX_PARITY_EN
    check("parity_err", {31'b0, parity_err}, {31'b0, ep});
`endif
    if (rx_done === 1'b1) begin
      last_done_cyc = cyc;
      done_count++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one complete frame and records what the receiver must report.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit bad_par);
    int t0;
    t0 = cyc;
    if (stop && !bad_par) begin
      exp_done[t0 + LAT] = 1'b1;
      exp_byte[t0 + LAT] = b;
    end
    if (!stop)   exp_ferr[t0 + LAT] = 1'b1;
    if (bad_par) exp_perr[t0 + LAT] = 1'b1;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ bad_par;
    tick(CPB);
`endif
    rx = stop;
    tick(CPB);
  endtask

  initial begin : stim
    int t_a;
    int dc;
    bit saw_busy;
    logic [7:0] ab;

    // Reset state
    tick(3);
    check("reset_rx_data",   {24'b0, rx_data}, 32'h00);
    check("reset_rx_done",   {31'b0, rx_done}, 32'h0);
    check("reset_rx_busy",   {31'b0, rx_busy}, 32'h0);
    check("reset_frame_err", {31'b0, frame_err}, 32'h0);
    n_rst = 1'b1;
    tick(5);

    // Single frame 0xA5
    t_a = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(10);
    check("a5_data",    {24'b0, rx_data}, 32'hA5);
    check("a5_latency", last_done_cyc - t_a, LAT_LIT);
    check("a5_count",   done_count, 1);
    check("a5_idle",    {31'b0, rx_busy}, 32'h0);

    // Back-to-back 0x3C, 0xC3 with no gap
    send_frame(8'h3C, 1'b1, 1'b0);
    check("b2b_first",  {24'b0, rx_data}, 32'h3C);
    send_frame(8'hC3, 1'b1, 1'b0);
    tick(10);
    check("b2b_second", {24'b0, rx_data}, 32'hC3);
    check("b2b_count",  done_count, 3);

    // Three-clock glitch: false start
    dc = done_count;
    saw_busy = 1'b0;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rx_busy) saw_busy = 1'b1;
    end
    tick(5);
    check("glitch_busy_seen", {31'b0, saw_busy}, 32'h1);
    check("glitch_idle",      {31'b0, rx_busy}, 32'h0);
    check("glitch_no_done",   done_count, dc);

    // Bad stop bit, line held low, then recovery
    send_frame(8'h55, 1'b0, 1'b0);
    tick(50);
    check("break_data_kept", {24'b0, rx_data}, 32'hC3);
    check("break_busy",      {31'b0, rx_busy}, 32'h1);
    rx = 1'b1;
    tick(20);
    check("break_released",  {31'b0, rx_busy}, 32'h0);
    send_frame(8'h12, 1'b1, 1'b0);
    tick(10);
    check("after_break_data", {24'b0, rx_data}, 32'h12);

    // Reset in the middle of a frame (during data bit 4)
    dc = done_count;
    ab = 8'h6B;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 5; i++) begin
      rx = ab[i];
      tick(CPB);
    end
    n_rst = 1'b0;
    rx = 1'b1;
    tick(2);
    check("midrst_data_in", {24'b0, rx_data}, 32'h00);
    check("midrst_busy_in", {31'b0, rx_busy}, 32'h0);
    n_rst = 1'b1;
    tick(30);
    check("midrst_data", {24'b0, rx_data}, 32'h00);
    check("midrst_busy", {31'b0, rx_busy}, 32'h0);
    check("midrst_none", done_count, dc);
    send_frame(8'hFF, 1'b1, 1'b0);
    tick(10);
    check("after_rst_data", {24'b0, rx_data}, 32'hFF);

`ifdef UART_RX_PARITY_EN
    // Parity: good then bad parity on 0x07
    send_frame(8'h07, 1'b1, 1'b0);
    tick(10);
    check("par_good_data", {24'b0, rx_data}, 32'h07);
    dc = done_count;
    send_frame(8'h07, 1'b1, 1'b1);
    tick(10);
    check("par_bad_nodone", done_count, dc);
`endif

    tick(20);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
